// File: rtl/dsc_stream_encoder_if.sv
// rtl/dsc_stream_encoder_if.sv - load and unary-stream handshake bundle for dsc_stream_encoder
interface dsc_stream_encoder_if #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2
);
  logic                                  start;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] bin_data_in;
  logic                                  ready;
  logic [NUM_INPUTS-1:0]                 stream_out;
  logic                                  stream_valid;
  logic                                  stream_ready;
  logic                                  stream_last;
  logic                                  done;

  // Encoder side: accepts operands, produces the streams.
  modport master (
    input  start, bin_data_in, stream_ready,
    output ready, stream_out, stream_valid, stream_last, done
  );

  // Environment side: issues operands, consumes the streams.
  modport slave (
    output start, bin_data_in, stream_ready,
    input  ready, stream_out, stream_valid, stream_last, done
  );
endinterface

// File: rtl/dsc_stream_encoder.sv
// rtl/dsc_stream_encoder.sv - binary-to-unary DSC stream encoder with clock-division sequencing (option: DSC_ENC_EARLY_TERM_EN)
module dsc_stream_encoder #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  dsc_stream_encoder_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DATA_WIDTH-1:0] CNT_MAX = {DATA_WIDTH{1'b1}};

  state_t state_q, state_d;

  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] op_q, op_src;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;

  logic                  ready_q, valid_q, last_q, done_q;
  logic [NUM_INPUTS-1:0] out_q;

  logic                  ready_d, valid_d, last_d, done_d;
  logic [NUM_INPUTS-1:0] out_d;

  logic accept, xfer, carry, all_max;
`ifdef DSC_ENC_EARLY_TERM_EN
  logic any_zero;
`endif

  assign accept = (state_q == IDLE) && bus.start;
  assign xfer   = (state_q == RUN) && valid_q && bus.stream_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode: a run ends on the transfer of the beat flagged last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (xfer && last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ripple carry across counters: cnt[i] steps only when all lower counters wrap.
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      cnt_inc[i] = cnt_q[i] + {{(DATA_WIDTH-1){1'b0}}, carry};
      carry      = carry & (cnt_q[i] == CNT_MAX);
    end
    cnt_d  = cnt_q;
    if (accept)    cnt_d = '0;
    else if (xfer) cnt_d = cnt_inc;
    op_src = accept ? bus.bin_data_in : op_q;
  end

  // Operand latch and beat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (accept) op_q <= bus.bin_data_in;
      cnt_q <= cnt_d;
    end
  end

  // Output decode from next state and next counters so every output is a flop.
  always_comb begin
    all_max = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      out_d[i] = (cnt_d[i] < op_src[i]);
      all_max  = all_max & (cnt_d[i] == CNT_MAX);
    end
    last_d = all_max;
`ifdef DSC_ENC_EARLY_TERM_EN
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      any_zero = any_zero | (op_src[i] == '0);
    end
    // A zero operand makes every product beat zero, so one final beat suffices.
    if (any_zero) begin
      out_d  = '0;
      last_d = 1'b1;
    end
`endif
    valid_d = (state_d == RUN);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
    if (!valid_d) begin
      out_d  = '0;
      last_d = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign bus.ready        = ready_q;
  assign bus.stream_valid = valid_q;
  assign bus.stream_last  = last_q;
  assign bus.stream_out   = out_q;
  assign bus.done         = done_q;

endmodule

// File: doc/dsc_stream_encoder.md
# dsc_stream_encoder

Deterministic-stochastic-computing front end that converts NUM_INPUTS binary operands into ordered unary bitstreams with clock-division sequencing, for the DSC multiplier datapaths in the arch sweep. It is the transmit end of the binary/stream boundary: it produces the bitstreams that a stream multiplier (AND) and a popcount decoder consume. It also drives those streams from testbench cores back into a `done`-style completion interface.

## Interface

- DATA_WIDTH, 5, operand width W; each stream has 2^W beats per period.
- NUM_INPUTS, 2, operand count N; a full run is 2^(W*N) beats.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  load request; accepted only when `ready`=1.
- bin_data_in  in  [DATA_WIDTH-1:0] x NUM_INPUTS  operands, sampled on accept.
- ready  out  1  high in IDLE.
- stream_out  out  NUM_INPUTS  one unary bit per operand for the current beat.
- stream_valid  out  1  current beat is valid.
- stream_ready  in  1  downstream accepts the beat (valid & ready = transfer).
- stream_last  out  1  current beat is the final beat of the run.
- done  out  1  one-cycle pulse after the final transfer.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: `ready`=1. On `start`, latch operands, clear all beat counters, and go to RUN.
- RUN: `stream_valid`=1.
  - Per-operand counter cnt[i] is W bits.
  - stream_out[i] = (cnt[i] < op[i]), i.e. op[i] ones per 2^W beats.
- Clock division on each transfer:
  - cnt[0] increments.
  - cnt[i] increments only when cnt[0..i-1] are all 2^W-1 (all wrap together).
- Bitwise AND of the streams over a full run yields exactly prod(op[i]) ones.
- `stream_last` = all cnt[i] at 2^W-1.
  - Transfer with last → DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Without a transfer (`stream_ready`=0): stream_out, stream_valid and stream_last hold stable, and the counters do not advance.
- `start` outside IDLE is ignored; latched operands are unchanged.
- Operand value 2^W-1 gives 2^W-1 ones per period (never all ones). Value 0 gives all zeros.
- Reset, asynchronous and at any time including mid-RUN:
  - state = IDLE; counters and operands = 0.
  - ready=1; stream_out=0; stream_valid=0; stream_last=0; done=0.

## Timing

- All outputs are registered.
- `start` accepted at edge t → `stream_valid`=1 with beat 0 from t+1; `ready`=0 from t+1.
- One beat per cycle under continuous `stream_ready`. A full run takes 2^(W*N) cycles of `stream_valid`.
- Final transfer at edge t → `done`=1 during cycle t+1, `ready`=1 from t+2.
- Minimum start-to-start: 2^(W*N)+2 cycles.

## Configuration

- DSC_ENC_EARLY_TERM_EN defined:
  - If any latched operand is 0, RUN emits a single beat: stream_out all zeros, stream_last=1.
  - Then DONE as normal.
- DSC_ENC_EARLY_TERM_EN undefined: zero operands run the full 2^(W*N) beats.

## Test plan

- W=5, N=2, ops (3,5), stream_ready=1 → 1024 valid beats; AND-popcount = 15; per-stream ones 96 and 160; stream_last only on beat 1023; done one cycle later.
- Ops (31,31) → AND-popcount = 961; ops (0,17) without macro → 1024 beats, popcount 0.
- Ops (0,17) with DSC_ENC_EARLY_TERM_EN → exactly one beat with stream_out=00 and stream_last=1, then done.
- Random stream_ready (≈50%), ops (12,20):
  - Outputs are stable across stalls.
  - Popcount = 240; 1024 transfers.
- rst_n low at beat 400 of a run:
  - All outputs go to reset values immediately.
  - After release, start with (1,1) → popcount 1.
- start pulsed mid-RUN with different operands → ignored; original product still produced.
